// File: rtl/pipelined_add_sub.sv
// Carry-pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per register stage,
// with a single global stall (advance) shared by every stage and the output register.
module pipelined_add_sub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK");
  end

  logic advance;

  // Per-stage registers: operands travel with the partial result so each stage sees its chunk.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, res_q;
  logic [STAGES-1:0]            carry_q, valid_q;
  logic                         ovf_q, zero_q, neg_q;

  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_res;
  logic [STAGES-1:0]            src_c, src_v;
  logic [STAGES-1:0][WIDTH-1:0] res_d;
  logic [STAGES-1:0]            carry_d;
  logic                         ovf_d, zero_d, neg_d, msb_carry;

  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance && !rst;

  // Subtraction is folded into stage 0 as a + ~b + !c_in; later stages only add.
  always_comb begin
    src_a   = '0;
    src_b   = '0;
    src_res = '0;
    src_c   = '0;
    src_v   = '0;
    src_a[0] = a;
    src_b[0] = op ? ~b : b;
    src_c[0] = op ? ~c_in : c_in;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_res[k] = res_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_v[k]   = valid_q[k-1];
    end
  end

  always_comb begin
    logic [CHUNK:0] chunk_sum;
    res_d     = '0;
    carry_d   = '0;
    chunk_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk_sum = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_c[k]};
      res_d[k] = src_res[k];
      res_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      carry_d[k] = chunk_sum[CHUNK];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_comb begin
    msb_carry = res_d[STAGES-1][WIDTH-1] ^ src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1];
    ovf_d     = msb_carry ^ carry_d[STAGES-1];
    zero_d    = (res_d[STAGES-1] == '0);
    neg_d     = res_d[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (advance) begin
      a_q     <= src_a;
      b_q     <= src_b;
      res_q   <= res_d;
      carry_q <= carry_d;
      valid_q <= src_v;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // The last stage's operand copies have no consumer.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=16, CHUNK=4, latency 4): expected results
// are queued on accept and compared on every output pop; stalls and async reset exercised.
module tb_pipelined_add_sub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t        expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  logic        holdValid  = 1'b0;
  logic [19:0] holdVec    = '0;

  pipelined_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model from integer arithmetic: borrow and signed range are judged directly.
  function automatic exp_t model(input logic opIn, input logic [15:0] aIn, input logic [15:0] bIn,
                                 input logic cIn);
    exp_t        r;
    int unsigned ua, ub, cu, full;
    int          sa, sb, sres;
    ua = 32'(aIn);
    ub = 32'(bIn);
    cu = 32'(cIn);
    sa = int'($signed(aIn));
    sb = int'($signed(bIn));
    if (!opIn) begin
      full = ua + ub + cu;
      r.c  = (full > 32'd65535);
      sres = sa + sb + int'(cu);
    end else begin
      full = ua + 32'd65536 - ub - cu;
      r.c  = (ua >= ub + cu);
      sres = sa - sb - int'(cu);
    end
    r.sum  = full[15:0];
    r.ovf  = (sres > 32767) || (sres < -32768);
    r.zero = (r.sum == 16'h0000);
    r.neg  = r.sum[15];
    return r;
  endfunction

  // Monitor: handshakes are judged mid-cycle, where inputs and outputs are both settled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      holdValid = 1'b0;
    end else begin
      checkOutput("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (holdValid)
        checkOutput("stall_hold", 64'({sum, c_out, ovf, zero, neg}), 64'(holdVec));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("sum",   64'(sum),   64'(e.sum));
          checkOutput("c_out", 64'(c_out), 64'(e.c));
          checkOutput("ovf",   64'(ovf),   64'(e.ovf));
          checkOutput("zero",  64'(zero),  64'(e.zero));
          checkOutput("neg",   64'(neg),   64'(e.neg));
        end
      end
      holdValid = out_valid && !out_ready;
      holdVec   = {sum, c_out, ovf, zero, neg};
      if (in_valid && in_ready)
        expQ.push_back(model(op, a, b, c_in));
    end
  end

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic opIn, input logic [15:0] aIn, input logic [15:0] bIn,
                               input logic cIn);
    logic accepted;
    int   tries;
    in_valid = 1'b1;
    op       = opIn;
    a        = aIn;
    b        = bIn;
    c_in     = cIn;
    accepted = 1'b0;
    tries    = 0;
    while (!accepted && tries < 100) begin
      @(negedge clk);
      accepted = in_valid && in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!accepted)
      checkOutput("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    op       = 1'bx;
    a        = 'x;
    b        = 'x;
    c_in     = 1'bx;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (expQ.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
  endtask

  task automatic measureLatency(input string tag);
    int lat;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(tag, 64'(lat), 64'(4));
  endtask

  initial begin
    logic readyPattern [4];
    readyPattern = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_sum",       64'(sum),       64'(0));
    checkOutput("rst_flags",     64'({c_out, ovf, zero, neg}), 64'(0));
    checkOutput("rst_in_ready",  64'(in_ready),  64'(0));
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    $display("[TB] add boundaries");
    applyStimulus(1'b0, 16'h8000, 16'h7FFF, 1'b0);
    measureLatency("latency_first");
    checkOutput("t1_sum", 64'(sum), 64'(16'hFFFF));
    checkOutput("t1_neg", 64'(neg), 64'(1));
    drain();
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0);
    drain();

    $display("[TB] subtract boundaries");
    applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b0);
    applyStimulus(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 16'h0008, 16'h0008, 1'b1);
    drain();

    $display("[TB] back-to-back with output stalls");
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)));
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 40; j++) begin
          out_ready = readyPattern[j % 4];
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] bubbles between beats");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)));
      idleCycles(1);
    end
    drain();

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b0, 16'h1234, 16'h1111, 1'b0);
    applyStimulus(1'b0, 16'h0101, 16'h0202, 1'b1);
    applyStimulus(1'b1, 16'h4000, 16'h0001, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("valid_before_rst", 64'(out_valid), 64'(1));
    #1;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async_rst_valid", 64'(out_valid), 64'(0));
    checkOutput("async_rst_sum",   64'(sum),       64'(0));
    checkOutput("async_rst_ready", 64'(in_ready),  64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst2", 64'(in_ready), 64'(1));
    idleCycles(8);
    applyStimulus(1'b0, 16'h00F0, 16'h000F, 1'b1);
    measureLatency("latency_after_rst");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
